dsp_mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate slice. It generalises the fixed 18x18/48-bit DSP slice with configurable operand, accumulator and input-pipeline widths, a valid strobe that travels with the data, and overflow detection with optional saturation. It sits in the arithmetic datapath wherever a cascadable pre-add/multiply/post-add/accumulate stage is needed.

---
 rtl/dsp_mac_pipe.sv | 163 ++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed pre-add / multiply / post-add / accumulate slice with a valid strobe.
// Overflow always flags ovf; defining DSP_MAC_SAT_EN clamps p on overflow instead of wrapping.
module dsp_mac_pipe #(
    parameter int unsigned AW   = 18,
    parameter int unsigned BW   = 18,
    parameter int unsigned PW   = 48,
    parameter int unsigned IREG = 1,
    parameter int unsigned MREG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] d,
    input  logic [BW-1:0] b,
    input  logic [PW-1:0] c,
    input  logic [PW-1:0] pcin,
    input  logic          cin,
    input  logic [4:0]    mode,
    output logic [PW-1:0] p,
    output logic [PW-1:0] pcout,
    output logic          out_valid,
    output logic          ovf
);
    localparam int unsigned XW = AW + 1;
    localparam int unsigned MW = AW + 1 + BW;
    localparam int unsigned RW = PW + 1;

    typedef struct packed {
        logic          valid;
        logic [4:0]    mode;
        logic          cin;
        logic [AW-1:0] a;
        logic [AW-1:0] d;
        logic [BW-1:0] b;
        logic [PW-1:0] c;
    } in_beat_t;

    // op carries mode[4:2]: post-adder sign and Z select
    typedef struct packed {
        logic          valid;
        logic [2:0]    op;
        logic          cin;
        logic [PW-1:0] c;
        logic [MW-1:0] m;
    } m_beat_t;

    in_beat_t beat_in;
    in_beat_t beat_x;
    m_beat_t  m_in;
    m_beat_t  m_out;

    logic signed [XW-1:0] x_c;
    logic signed [MW-1:0] m_c;
    logic signed [RW-1:0] z_c;
    logic signed [RW-1:0] madd_c;
    logic signed [RW-1:0] r_c;
    logic [PW-1:0]        p_next_c;
    logic                 ovf_c;

    assign beat_in = '{valid: in_valid, mode: mode, cin: cin, a: a, d: d, b: b, c: c};

    // Input register chain: 0, 1 or 2 stages
    if (IREG == 0) begin : g_ireg0
        assign beat_x = beat_in;
    end else if (IREG == 1) begin : g_ireg1
        in_beat_t q1;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q1 <= '0;
            end else if (ce) begin
                q1 <= beat_in;
            end
        end
        assign beat_x = q1;
    end else begin : g_ireg2
        in_beat_t q1;
        in_beat_t q2;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q1 <= '0;
                q2 <= '0;
            end else if (ce) begin
                q1 <= beat_in;
                q2 <= q1;
            end
        end
        assign beat_x = q2;
    end

    // Pre-adder at AW+1 bits so d +/- a never wraps
    always_comb begin
        x_c = XW'($signed(beat_x.a));
        if (beat_x.mode[0]) begin
            if (beat_x.mode[1]) begin
                x_c = XW'($signed(beat_x.d)) - XW'($signed(beat_x.a));
            end else begin
                x_c = XW'($signed(beat_x.d)) + XW'($signed(beat_x.a));
            end
        end
    end

    assign m_c  = MW'(x_c) * MW'($signed(beat_x.b));
    assign m_in = '{valid: beat_x.valid, op: beat_x.mode[4:2], cin: beat_x.cin,
                    c: beat_x.c, m: m_c};

    if (MREG == 0) begin : g_mreg0
        assign m_out = m_in;
    end else begin : g_mreg1
        m_beat_t mq;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mq <= '0;
            end else if (ce) begin
                mq <= m_in;
            end
        end
        assign m_out = mq;
    end

    // Z mux and post-adder at PW+1 bits; the extra bit exposes overflow
    always_comb begin
        z_c = '0;
        case (m_out.op[1:0])
            2'd1:    z_c = RW'($signed(p));
            2'd2:    z_c = RW'($signed(m_out.c));
            2'd3:    z_c = RW'($signed(pcin));
            default: z_c = '0;
        endcase
        madd_c = RW'($signed(m_out.m)) + $signed(RW'(m_out.cin));
        if (m_out.op[2]) begin
            r_c = z_c - madd_c;
        end else begin
            r_c = z_c + madd_c;
        end
        ovf_c    = r_c[RW-1] ^ r_c[RW-2];
        p_next_c = r_c[PW-1:0];
`ifdef DSP_MAC_SAT_EN
        if (ovf_c) begin
            p_next_c = r_c[RW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
`endif
    end

    // P stage: only a valid beat updates the result and its overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= m_out.valid;
            if (m_out.valid) begin
                p   <= p_next_c;
                ovf <= ovf_c;
            end
        end
    end

    assign pcout = p;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: default 18x18/48 slice plus a 7x7/16 slice for overflow.
module tb_dsp_mac_pipe;
    localparam int unsigned AW  = 18;
    localparam int unsigned BW  = 18;
    localparam int unsigned PW  = 48;
    localparam int unsigned SAW = 7;
    localparam int unsigned SBW = 7;
    localparam int unsigned SPW = 16;
`ifdef DSP_MAC_SAT_EN
    localparam longint OVF_P = 32767;
`else
    localparam longint OVF_P = -29815;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic [AW-1:0] a;
    logic [AW-1:0] d;
    logic [BW-1:0] b;
    logic [PW-1:0] c;
    logic [PW-1:0] pcin;
    logic          cin;
    logic [4:0]    mode;
    logic [PW-1:0] p;
    logic [PW-1:0] pcout;
    logic          out_valid;
    logic          ovf;

    logic           s_valid;
    logic [SAW-1:0] s_a;
    logic [SAW-1:0] s_d;
    logic [SBW-1:0] s_b;
    logic [SPW-1:0] s_c;
    logic [SPW-1:0] s_pcin;
    logic           s_cin;
    logic [4:0]     s_mode;
    logic [SPW-1:0] s_p;
    logic [SPW-1:0] s_pcout;
    logic           s_out_valid;
    logic           s_ovf;

    always #5 clk = ~clk;

    dsp_mac_pipe dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .a(a), .d(d), .b(b), .c(c), .pcin(pcin), .cin(cin), .mode(mode),
        .p(p), .pcout(pcout), .out_valid(out_valid), .ovf(ovf)
    );

    dsp_mac_pipe #(.AW(SAW), .BW(SBW), .PW(SPW), .IREG(1), .MREG(1)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(s_valid),
        .a(s_a), .d(s_d), .b(s_b), .c(s_c), .pcin(s_pcin), .cin(s_cin), .mode(s_mode),
        .p(s_p), .pcout(s_pcout), .out_valid(s_out_valid), .ovf(s_ovf)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0] mode;
        longint     a;
        longint     b;
        longint     d;
        longint     c;
        logic       cin;
        longint     ep;
    } vec_t;

    vec_t   vq[$];
    longint last_p;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] md, input longint va, input longint vb,
                         input longint vd, input longint vc, input logic vcin);
        in_valid = v;
        mode     = md;
        a        = AW'(va);
        b        = BW'(vb);
        d        = AW'(vd);
        c        = PW'(vc);
        cin      = vcin;
    endtask

    task automatic push(input logic [4:0] md, input longint va, input longint vb, input longint vd,
                        input longint vc, input logic vcin, input longint ep);
        vec_t v;
        v.mode = md; v.a = va; v.b = vb; v.d = vd; v.c = vc; v.cin = vcin; v.ep = ep;
        vq.push_back(v);
    endtask

    // Stream the queued beats back to back; result k is due three cycles after beat k
    task automatic run_vecs(input string tag);
        int n = vq.size();
        for (int j = 0; j < n + 3; j++) begin
            if (j < n) drive(1'b1, vq[j].mode, vq[j].a, vq[j].b, vq[j].d, vq[j].c, vq[j].cin);
            else       drive(1'b0, 5'h00, 0, 0, 0, 0, 1'b0);
            @(negedge clk);
            if (j >= 2 && j - 2 < n) begin
                chk({tag, ".valid"}, out_valid, 1);
                chk({tag, ".p"}, $signed(p), vq[j-2].ep);
                chk({tag, ".pcout"}, $signed(pcout), vq[j-2].ep);
                chk({tag, ".ovf"}, ovf, 0);
                last_p = vq[j-2].ep;
            end else begin
                chk({tag, ".idle_valid"}, out_valid, 0);
                chk({tag, ".hold_p"}, $signed(p), last_p);
            end
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'h00, 0, 0, 0, 0, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        last_p = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        pcin = PW'(1000);
        drive(1'b0, 5'h00, 0, 0, 0, 0, 1'b0);
        s_valid = 1'b0; s_mode = 5'h04; s_a = '0; s_b = '0; s_d = '0;
        s_c = '0; s_pcin = '0; s_cin = 1'b0;
        last_p = 0;
        @(negedge clk);
        chk("reset.p", $signed(p), 0);
        chk("reset.pcout", $signed(pcout), 0);
        chk("reset.valid", out_valid, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.s_p", $signed(s_p), 0);
        rst = 1'b0;

        // single multiply: out_valid for exactly one cycle, three cycles after the beat
        push(5'h00, 3, 5, 0, 0, 1'b0, 15);
        run_vecs("mul");

        // independent beats exercising pre-adder, Z sources, cin and operand extremes
        push(5'h01, 4, -3, 10, 0, 1'b0, -42);
        push(5'h03, 4, -3, 10, 0, 1'b0, -18);
        push(5'h18, 7, 7, 0, 100, 1'b1, 50);
        push(5'h0C, -5, 4, 0, 0, 1'b0, 980);
        push(5'h08, 1, 1, 0, -7, 1'b1, -5);
        push(5'h10, 3, 4, 0, 0, 1'b0, -12);
        push(5'h00, 2, 2, 0, 0, 1'b1, 5);
        push(5'h00, -131072, -131072, 0, 0, 1'b0, 64'sd17179869184);
        push(5'h01, -131072, 131071, -131072, 0, 1'b0, -64'sd34359476224);
        push(5'h03, 131071, -131072, -131072, 0, 1'b0, 64'sd34359607296);
        run_vecs("mix");

        // back-to-back accumulate, then subtract-from-accumulator
        do_reset();
        push(5'h04, 2, 3, 0, 0, 1'b0, 6);
        push(5'h04, 2, 3, 0, 0, 1'b0, 12);
        push(5'h04, 2, 3, 0, 0, 1'b0, 18);
        push(5'h04, 2, 3, 0, 0, 1'b0, 24);
        push(5'h14, 2, 3, 0, 0, 1'b1, 17);
        run_vecs("acc");

        // hold with ce=0 while a third beat is in flight, then async reset discards it
        do_reset();
        for (int j = 0; j < 4; j++) begin
            if (j < 3) drive(1'b1, 5'h04, 2, 3, 0, 0, 1'b0);
            else       drive(1'b0, 5'h00, 0, 0, 0, 0, 1'b0);
            @(negedge clk);
        end
        chk("hold.pre_p", $signed(p), 12);
        chk("hold.pre_valid", out_valid, 1);
        ce = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("hold.p", $signed(p), 12);
            chk("hold.valid", out_valid, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst.p", $signed(p), 0);
        chk("arst.pcout", $signed(pcout), 0);
        chk("arst.valid", out_valid, 0);
        chk("arst.ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("flush.valid", out_valid, 0);
            chk("flush.p", $signed(p), 0);
        end
        last_p = 0;
        push(5'h04, 2, 3, 0, 0, 1'b0, 6);
        run_vecs("post_rst");

        // 7x7/16 slice: eight accumulations fit, the ninth overflows, a fresh multiply clears ovf
        do_reset();
        for (int j = 0; j < 12; j++) begin
            s_valid = (j < 10);
            s_mode  = (j == 9) ? 5'h00 : 5'h04;
            s_a     = (j == 9) ? SAW'(1) : SAW'(63);
            s_b     = (j == 9) ? SBW'(1) : SBW'(63);
            @(negedge clk);
            if (j >= 2) begin
                if (j - 2 < 8) begin
                    chk("ovf.p", $signed(s_p), 3969 * (j - 1));
                    chk("ovf.flag", s_ovf, 0);
                end else if (j - 2 == 8) begin
                    chk("ovf.p9", $signed(s_p), OVF_P);
                    chk("ovf.flag9", s_ovf, 1);
                    chk("ovf.pcout9", $signed(s_pcout), OVF_P);
                end else begin
                    chk("ovf.p10", $signed(s_p), 1);
                    chk("ovf.flag10", s_ovf, 0);
                end
                chk("ovf.valid", s_out_valid, (j - 2 < 10) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
